// File: rtl/rtc_pkg.sv
// Shared constants for the RTC display path: digit geometry, inactive drive
// patterns and the digit-select decoder.
package rtc_pkg;

    localparam int NUM_DIGITS          = 6;
    localparam int NUM_DIG_LINES       = 8;
    localparam int IDX_W               = 3;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [7:0] DIG_OFF_AL = 8'hFF;
    localparam logic [7:0] DIG_OFF_AH = 8'h00;
    localparam logic [7:0] SEG_OFF_AL = 8'hFF;
    localparam logic [7:0] SEG_OFF_AH = 8'h00;

    typedef logic [IDX_W-1:0] dig_idx_t;

    localparam dig_idx_t LAST_DIGIT = dig_idx_t'(NUM_DIGITS - 1);

    // Unreachable indices still decode to digit 0 so exactly one line is ever enabled.
    function automatic logic [NUM_DIG_LINES-1:0] digit_onehot(input dig_idx_t idx);
        logic [NUM_DIG_LINES-1:0] oh;
        case (idx)
            3'd0:    oh = 8'b0000_0001;
            3'd1:    oh = 8'b0000_0010;
            3'd2:    oh = 8'b0000_0100;
            3'd3:    oh = 8'b0000_1000;
            3'd4:    oh = 8'b0001_0000;
            3'd5:    oh = 8'b0010_0000;
            default: oh = 8'b0000_0001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Refresh prescaler: counts 0..DIV-1 and flags the terminal count for one cycle.
module rtc_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic sclk_i,
    input  logic reset_n_i,
    output logic tick_o
);

    localparam int             CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/rtc_adapter.sv
// Six-digit multiplexed 7-segment driver: scans one digit per refresh slot
// and registers the selected pattern and digit enable.
module rtc_adapter
    import rtc_pkg::*;
#(
    parameter int REFRESH_DIV    = DEFAULT_REFRESH_DIV,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       i_sclk,
    input  logic       i_reset_n,
    input  logic [7:0] i_segout1,
    input  logic [7:0] i_segout2,
    input  logic [7:0] i_segout3,
    input  logic [7:0] i_segout4,
    input  logic [7:0] i_segout5,
    input  logic [7:0] i_segout6,
    output logic [7:0] o_segments,
    output logic [7:0] o_digits
);

    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : SEG_OFF_AH;
    localparam logic [7:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? DIG_OFF_AL : DIG_OFF_AH;

    logic       tick;
    dig_idx_t   idx_q, idx_d;
    logic [7:0] seg_q, seg_d;
    logic [7:0] dig_q, dig_d;
    logic [7:0] sel_seg;
    logic [7:0] onehot;

    rtc_tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick_gen (
        .sclk_i    (i_sclk),
        .reset_n_i (i_reset_n),
        .tick_o    (tick)
    );

    always_comb begin
        idx_d = idx_q;
        if (idx_q > LAST_DIGIT) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = (idx_q == LAST_DIGIT) ? dig_idx_t'(0) : idx_q + 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    sel_seg = i_segout1;
            3'd1:    sel_seg = i_segout2;
            3'd2:    sel_seg = i_segout3;
            3'd3:    sel_seg = i_segout4;
            3'd4:    sel_seg = i_segout5;
            3'd5:    sel_seg = i_segout6;
            default: sel_seg = i_segout1;
        endcase
        onehot = digit_onehot(idx_q);
        seg_d  = (SEG_ACTIVE_LOW != 0) ? ~sel_seg : sel_seg;
        dig_d  = (DIG_ACTIVE_LOW != 0) ? ~onehot  : onehot;
    end

    // Outputs reflect the index and inputs seen at the previous edge.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_q <= '0;
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign o_segments = seg_q;
    assign o_digits   = dig_q;

endmodule

// File: tb/tb_rtc_adapter.sv
// Scoreboard bench for rtc_adapter: REFRESH_DIV=4 and REFRESH_DIV=1 instances
// share clock, reset and segment inputs.
module tb_rtc_adapter;

    typedef struct {
        logic [7:0] dig4;
        logic [7:0] seg4;
        logic [7:0] dig1;
        logic [7:0] seg1;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in [6];
    logic [7:0] seg4, dig4, seg1, dig1;
    logic       armed;

    int   n_checks;
    int   n_errors;
    int   n_edge;
    exp_t sb_q[$];

    logic [7:0] tbl_dig [7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE};
    logic [7:0] tbl_seg [7] = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'hEE};

    rtc_adapter #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut4 (
        .i_sclk     (clk),
        .i_reset_n  (rst_n),
        .i_segout1  (seg_in[0]),
        .i_segout2  (seg_in[1]),
        .i_segout3  (seg_in[2]),
        .i_segout4  (seg_in[3]),
        .i_segout5  (seg_in[4]),
        .i_segout6  (seg_in[5]),
        .o_segments (seg4),
        .o_digits   (dig4)
    );

    rtc_adapter #(.REFRESH_DIV(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut1 (
        .i_sclk     (clk),
        .i_reset_n  (rst_n),
        .i_segout1  (seg_in[0]),
        .i_segout2  (seg_in[1]),
        .i_segout3  (seg_in[2]),
        .i_segout4  (seg_in[3]),
        .i_segout5  (seg_in[4]),
        .i_segout6  (seg_in[5]),
        .o_segments (seg1),
        .o_digits   (dig1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent scan model: edge n after release shows digit ((n-1)/div) mod 6.
    function automatic int exp_idx(input int n, input int div);
        return ((n - 1) / div) % 6;
    endfunction

    function automatic logic [7:0] exp_dig(input int idx);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << idx);
    endfunction

    task automatic step();
        exp_t e;
        int   i4, i1;
        n_edge++;
        i4 = exp_idx(n_edge, 4);
        i1 = exp_idx(n_edge, 1);
        e.dig4 = exp_dig(i4);
        e.seg4 = ~seg_in[i4];
        e.dig1 = exp_dig(i1);
        e.seg1 = ~seg_in[i1];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            chk("dig4", dig4, e.dig4);
            chk("seg4", seg4, e.seg4);
            chk("dig1", dig1, e.dig1);
            chk("seg1", seg1, e.seg1);
        end
    endtask

    task automatic rst_step(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_dig4"}, dig4, 8'hFF);
        chk({tag, "_seg4"}, seg4, 8'hFF);
        chk({tag, "_dig1"}, dig1, 8'hFF);
        chk({tag, "_seg1"}, seg1, 8'hFF);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed && rst_n) begin
            chk("dig76_4", {6'b0, dig4[7:6]}, 8'h03);
            chk("onehot_4", 8'($countones(~dig4[5:0])), 8'd1);
            chk("dig76_1", {6'b0, dig1[7:6]}, 8'h03);
            chk("onehot_1", 8'($countones(~dig1[5:0])), 8'd1);
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_edge   = 0;
        rst_n    = 1'b0;
        seg_in[0] = 8'h11; seg_in[1] = 8'h22; seg_in[2] = 8'h33;
        seg_in[3] = 8'h44; seg_in[4] = 8'h55; seg_in[5] = 8'h66;

        repeat (10) rst_step("rst");

        rst_n  = 1'b1;
        n_edge = 0;
        for (int n = 1; n <= 25; n++) begin
            step();
            if ((n - 1) % 4 == 0) begin
                chk("scan_dig", dig4, tbl_dig[(n - 1) / 4]);
                chk("scan_seg", seg4, tbl_seg[(n - 1) / 4]);
            end
            if (n <= 7) begin
                chk("div1_dig", dig1, tbl_dig[n - 1]);
            end
        end

        seg_in[0] = 8'hA5;
        step();
        chk("midslot_seg", seg4, 8'h5A);
        chk("midslot_dig", dig4, 8'hFE);
        seg_in[0] = 8'h11;

        while (n_edge < 38) step();
        chk("pre_rst_dig", dig4, 8'hF7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_dig4", dig4, 8'hFF);
        chk("async_seg4", seg4, 8'hFF);
        chk("async_dig1", dig1, 8'hFF);
        chk("async_seg1", seg1, 8'hFF);
        repeat (3) rst_step("rst2");

        rst_n  = 1'b1;
        n_edge = 0;
        step();
        chk("restart_dig", dig4, 8'hFE);
        chk("restart_seg", seg4, 8'hEE);
        repeat (7) step();

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
